// File: rtl/core_pkg.sv
// Shared types for the core sequencer: instruction classes,
// trap causes and sequencer states.
package core_pkg;

  localparam int ILEN = 32;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_LOAD   = 3'd1,
    CLS_STORE  = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_JUMP   = 3'd4,
    CLS_SYSTEM = 3'd5
  } instr_class_e;

  typedef enum logic [1:0] {
    TC_ILLEGAL    = 2'd0,
    TC_MISALIGNED = 2'd1,
    TC_TIMEOUT    = 2'd2,
    TC_ECALL      = 2'd3
  } trap_cause_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_REGRD,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } seq_state_e;

  function automatic logic is_legal(
    input logic [2:0] c
  );
    return c <= 3'd5;
  endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage wait counter; o_expired flags the last allowed
// cycle of a stage. TIMEOUT=0 disables it.
module stage_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned W =
    (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST =
    W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [W-1:0] r_cnt;

  // Saturates at LAST so a disabled watchdog never wraps
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && r_cnt != LAST) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_expired = (TIMEOUT != 0) && i_enable &&
                     (r_cnt == LAST);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer with watchdog and traps.
// Define SEQ_PERF_CNT_EN to add cycle/instret counters.
module core_sequencer
  import core_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     TIMEOUT  = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  output logic            fetch_enable,
  input  logic            fetch_done,
  output logic [XLEN-1:0] fetch_addr,
  output logic            decode_enable,
  input  logic            decode_done,
  input  logic [2:0]      instr_class,
  input  logic [4:0]      rd,
  output logic            reg_read_enable,
  input  logic            reg_read_done,
  output logic            alu_enable,
  input  logic            alu_done,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] branch_target,
  input  logic            branch_taken,
  output logic            mem_read_enable,
  output logic            mem_write_enable,
  input  logic            mem_done,
  output logic [XLEN-1:0] mem_address,
  input  logic [XLEN-1:0] mem_read_data,
  output logic            reg_write_enable,
  input  logic            reg_write_done,
  output logic [4:0]      reg_write_addr,
  output logic [XLEN-1:0] reg_write_data,
  output logic            retire,
  output logic            busy,
  output logic            trap,
  output logic [1:0]      trap_cause
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [63:0]     cycle_count,
  output logic [63:0]     instret_count
`endif
);

  seq_state_e   r_state, w_next;
  instr_class_e r_cls;
  trap_cause_e  r_cause, w_cause;

  logic [XLEN-1:0] r_pc, r_target, r_maddr, r_wdata;
  logic [XLEN-1:0] w_target, w_pc_next;
  logic [4:0]      r_rd;
  logic            r_taken, r_retire;
  logic            w_taken, w_retire, w_trap;
  logic            w_busy, w_expired;

  assign w_busy = (r_state != S_IDLE) &&
                  (r_state != S_TRAP);

  stage_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_next != r_state),
    .i_enable  (w_busy),
    .o_expired (w_expired)
  );

  // Branch info is live in EXEC, latched afterwards
  assign w_taken   = (r_state == S_EXEC) ?
                     branch_taken : r_taken;
  assign w_target  = (r_state == S_EXEC) ?
                     branch_target : r_target;
  assign w_pc_next = w_taken ? w_target :
                     r_pc + XLEN'(4);

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    w_trap   = 1'b0;
    w_cause  = TC_ILLEGAL;
    unique case (r_state)
      S_IDLE:
        if (enable) w_next = S_FETCH;
      S_FETCH:
        if (fetch_done) w_next = S_DECODE;
      S_DECODE:
        if (decode_done) begin
          if (is_legal(instr_class)) begin
            w_next = S_REGRD;
          end else begin
            w_trap  = 1'b1;
            w_cause = TC_ILLEGAL;
          end
        end
      S_REGRD:
        if (reg_read_done) w_next = S_EXEC;
      S_EXEC:
        if (alu_done) begin
          if (r_cls == CLS_SYSTEM) begin
            w_trap  = 1'b1;
            w_cause = TC_ECALL;
          end else if (branch_taken &&
                       branch_target[1:0] != 2'b00) begin
            w_trap  = 1'b1;
            w_cause = TC_MISALIGNED;
          end else if (r_cls == CLS_LOAD ||
                       r_cls == CLS_STORE) begin
            w_next = S_MEM;
          end else if (r_cls == CLS_BRANCH ||
                       r_rd == 5'd0) begin
            w_retire = 1'b1;
          end else begin
            w_next = S_WB;
          end
        end
      S_MEM:
        if (mem_done) begin
          if (r_cls == CLS_LOAD && r_rd != 5'd0)
            w_next = S_WB;
          else
            w_retire = 1'b1;
        end
      S_WB:
        if (reg_write_done) w_retire = 1'b1;
      S_TRAP:
        w_next = S_TRAP;
      default:
        w_next = S_IDLE;
    endcase
    if (w_retire) w_next = enable ? S_FETCH : S_IDLE;
    if (!w_trap && w_expired && w_next == r_state) begin
      w_trap  = 1'b1;
      w_cause = TC_TIMEOUT;
    end
    if (w_trap) w_next = S_TRAP;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_cls    <= CLS_ALU;
      r_rd     <= '0;
      r_taken  <= 1'b0;
      r_target <= '0;
      r_maddr  <= '0;
      r_wdata  <= '0;
      r_retire <= 1'b0;
      r_cause  <= TC_ILLEGAL;
    end else begin
      r_state  <= w_next;
      r_retire <= w_retire;
      if (w_trap) r_cause <= w_cause;
      if (r_state == S_DECODE && decode_done) begin
        r_cls <= instr_class_e'(instr_class);
        r_rd  <= rd;
      end
      if (r_state == S_EXEC && alu_done) begin
        r_taken  <= branch_taken;
        r_target <= branch_target;
        r_maddr  <= alu_result;
        r_wdata  <= (r_cls == CLS_JUMP) ?
                    r_pc + XLEN'(4) : alu_result;
      end
      if (r_state == S_MEM && mem_done &&
          r_cls == CLS_LOAD) begin
        r_wdata <= mem_read_data;
      end
      if (w_retire) r_pc <= w_pc_next;
    end
  end

  assign fetch_enable     = (r_state == S_FETCH);
  assign decode_enable    = (r_state == S_DECODE);
  assign reg_read_enable  = (r_state == S_REGRD);
  assign alu_enable       = (r_state == S_EXEC);
  assign mem_read_enable  = (r_state == S_MEM) &&
                            (r_cls == CLS_LOAD);
  assign mem_write_enable = (r_state == S_MEM) &&
                            (r_cls == CLS_STORE);
  assign reg_write_enable = (r_state == S_WB);
  assign fetch_addr       = r_pc;
  assign mem_address      = r_maddr;
  assign reg_write_addr   = r_rd;
  assign reg_write_data   = r_wdata;
  assign retire           = r_retire;
  assign busy             = w_busy;
  assign trap             = (r_state == S_TRAP);
  assign trap_cause       = r_cause;

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      if (w_busy) cycle_count <= cycle_count + 64'd1;
      if (r_retire)
        instret_count <= instret_count + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Directed vector bench for core_sequencer: table of
// instructions plus hand-written trap/reset sequences.
module tb_core_sequencer;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic reset, enable;
  logic fetch_enable, fetch_done;
  logic [XLEN-1:0] fetch_addr;
  logic decode_enable, decode_done;
  logic [2:0] instr_class;
  logic [4:0] rd;
  logic reg_read_enable, reg_read_done;
  logic alu_enable, alu_done;
  logic [XLEN-1:0] alu_result, branch_target;
  logic branch_taken;
  logic mem_read_enable, mem_write_enable, mem_done;
  logic [XLEN-1:0] mem_address, mem_read_data;
  logic reg_write_enable, reg_write_done;
  logic [4:0] reg_write_addr;
  logic [XLEN-1:0] reg_write_data;
  logic retire, busy, trap;
  logic [1:0] trap_cause;
`ifdef SEQ_PERF_CNT_EN
  logic [63:0] cycle_count, instret_count;
`endif

  always #5 clk = ~clk;

  core_sequencer #(
    .XLEN(XLEN), .RESET_PC(32'h100), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .fetch_enable(fetch_enable),
    .fetch_done(fetch_done),
    .fetch_addr(fetch_addr),
    .decode_enable(decode_enable),
    .decode_done(decode_done),
    .instr_class(instr_class), .rd(rd),
    .reg_read_enable(reg_read_enable),
    .reg_read_done(reg_read_done),
    .alu_enable(alu_enable), .alu_done(alu_done),
    .alu_result(alu_result),
    .branch_target(branch_target),
    .branch_taken(branch_taken),
    .mem_read_enable(mem_read_enable),
    .mem_write_enable(mem_write_enable),
    .mem_done(mem_done),
    .mem_address(mem_address),
    .mem_read_data(mem_read_data),
    .reg_write_enable(reg_write_enable),
    .reg_write_done(reg_write_done),
    .reg_write_addr(reg_write_addr),
    .reg_write_data(reg_write_data),
    .retire(retire), .busy(busy),
    .trap(trap), .trap_cause(trap_cause)
`ifdef SEQ_PERF_CNT_EN
    ,
    .cycle_count(cycle_count),
    .instret_count(instret_count)
`endif
  );

  typedef struct {
    logic [2:0]  cls;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic        taken;
    logic [31:0] tgt;
    logic [31:0] mdata;
    int          mdly;
    bit          hang;
    bit          drop;
    logic [31:0] pc;
    int          cyc;
    bit          wb;
    logic [31:0] wdata;
    bit          trap;
    logic [1:0]  cause;
    int          mcyc;
  } vec_t;

  int checks = 0;
  int failures = 0;
  vec_t tbl[11];
  vec_t tv;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [6:0] enables();
    return {fetch_enable, decode_enable,
            reg_read_enable, alu_enable,
            mem_read_enable, mem_write_enable,
            reg_write_enable};
  endfunction

  task automatic clear_dones();
    fetch_done     = 1'b0;
    decode_done    = 1'b0;
    alu_done       = 1'b0;
    mem_done       = 1'b0;
    reg_write_done = 1'b0;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    clear_dones();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Called just after a negedge; returns at retire/trap negedge
  task automatic run_vec(input vec_t v, input string nm);
    int n = 0;
    int cyc = 0;
    int mcnt = 0;
    int aluc = 0;
    bit swb = 0;
    logic [31:0] wd = '0;
    logic [31:0] ma = '0;
    logic [4:0]  wa = '0;
    logic [31:0] pc0;
    while (!fetch_enable && n < 20) begin
      clear_dones();
      @(negedge clk);
      n++;
    end
    pc0 = fetch_addr;
    instr_class   = v.cls;
    rd            = v.rd;
    alu_result    = v.alu;
    branch_taken  = v.taken;
    branch_target = v.tgt;
    mem_read_data = v.mdata;
    while (cyc < 40) begin
      if (cyc > 0 && (retire || trap)) break;
      if (reg_write_enable) begin
        swb = 1;
        wd  = reg_write_data;
        wa  = reg_write_addr;
      end
      if (mem_read_enable || mem_write_enable)
        ma = mem_address;
      if (alu_enable) aluc++;
      if (v.drop && alu_enable) enable = 1'b0;
      fetch_done     = fetch_enable;
      decode_done    = decode_enable;
      alu_done       = alu_enable && !v.hang;
      mem_done       = (mem_read_enable ||
                        mem_write_enable) &&
                       (mcnt >= v.mdly);
      reg_write_done = reg_write_enable;
      if (mem_read_enable || mem_write_enable) mcnt++;
      @(negedge clk);
      cyc++;
    end
    chk({nm, " pc"}, pc0, v.pc);
    chk({nm, " cycles"}, cyc, v.cyc);
    chk({nm, " trap"}, trap, v.trap);
    if (v.trap) begin
      chk({nm, " cause"}, trap_cause, v.cause);
      chk({nm, " enables"}, enables(), 0);
      chk({nm, " pc_kept"}, fetch_addr, v.pc);
      chk({nm, " busy"}, busy, 0);
      chk({nm, " retire"}, retire, 0);
    end else begin
      chk({nm, " wb"}, swb, v.wb);
      if (v.wb) begin
        chk({nm, " wdata"}, wd, v.wdata);
        chk({nm, " waddr"}, wa, v.rd);
      end
      chk({nm, " memcyc"}, mcnt, v.mcyc);
      if (v.mcyc > 0) chk({nm, " maddr"}, ma, v.alu);
      if (v.drop) begin
        chk({nm, " idle_busy"}, busy, 0);
        chk({nm, " idle_fetch"}, fetch_enable, 0);
      end
    end
    if (v.hang) chk({nm, " exec_cycles"}, aluc, 8);
  endtask

  initial begin
    reg_read_done = 1'b1;
    instr_class   = '0;
    rd            = '0;
    alu_result    = '0;
    branch_target = '0;
    branch_taken  = 1'b0;
    mem_read_data = '0;
    @(negedge clk);
    do_reset();

    chk("rst pc", fetch_addr, 32'h100);
    chk("rst enables", enables(), 0);
    chk("rst busy", busy, 0);
    chk("rst trap", {trap, trap_cause}, 0);
    chk("rst retire", retire, 0);
    chk("rst data", {reg_write_data, mem_address}, 0);

    //         cls rd alu  tk tgt  mdata dly h d pc cyc wb wdata tr c mc
    tbl[0]  = '{3'd0, 5'd5, 32'hDEADBEEF, 1'b0, 32'h0,
                32'hAAAA5555, 0, 0, 0, 32'h100, 5,
                1, 32'hDEADBEEF, 0, 2'd0, 0};
    tbl[1]  = '{3'd3, 5'd3, 32'h0, 1'b1, 32'h200,
                32'h0, 0, 0, 0, 32'h104, 4,
                0, 32'h0, 0, 2'd0, 0};
    tbl[2]  = '{3'd1, 5'd7, 32'h40, 1'b0, 32'h0,
                32'h12345678, 3, 0, 0, 32'h200, 9,
                1, 32'h12345678, 0, 2'd0, 4};
    tbl[3]  = '{3'd2, 5'd9, 32'h80, 1'b0, 32'h0,
                32'h0, 0, 0, 0, 32'h204, 5,
                0, 32'h0, 0, 2'd0, 1};
    tbl[4]  = '{3'd4, 5'd1, 32'h0, 1'b1, 32'h300,
                32'h0, 0, 0, 0, 32'h208, 5,
                1, 32'h20C, 0, 2'd0, 0};
    tbl[5]  = '{3'd0, 5'd0, 32'h77, 1'b0, 32'h0,
                32'h0, 0, 0, 0, 32'h300, 4,
                0, 32'h0, 0, 2'd0, 0};
    tbl[6]  = '{3'd3, 5'd0, 32'h0, 1'b0, 32'h500,
                32'h0, 0, 0, 0, 32'h304, 4,
                0, 32'h0, 0, 2'd0, 0};
    tbl[7]  = '{3'd3, 5'd0, 32'h0, 1'b1, 32'hFFFFFFFC,
                32'h0, 0, 0, 0, 32'h308, 4,
                0, 32'h0, 0, 2'd0, 0};
    tbl[8]  = '{3'd0, 5'd2, 32'h5, 1'b0, 32'h0,
                32'h0, 0, 0, 0, 32'hFFFFFFFC, 5,
                1, 32'h5, 0, 2'd0, 0};
    tbl[9]  = '{3'd0, 5'd3, 32'h11, 1'b0, 32'h0,
                32'h0, 0, 0, 0, 32'h0, 5,
                1, 32'h11, 0, 2'd0, 0};
    tbl[10] = '{3'd0, 5'd4, 32'h22, 1'b0, 32'h0,
                32'h0, 0, 0, 1, 32'h4, 5,
                1, 32'h22, 0, 2'd0, 0};

    enable = 1'b1;
    for (int i = 0; i < 11; i++)
      run_vec(tbl[i], $sformatf("v%0d", i));

    // Misaligned branch target, then TRAP must hold
    enable = 1'b1;
    tv = '{3'd3, 5'd0, 32'h0, 1'b1, 32'h202,
           32'h0, 0, 0, 0, 32'h8, 4,
           0, 32'h0, 1, 2'd1, 0};
    run_vec(tv, "misalign");
    repeat (3) @(negedge clk);
    chk("trap hold", {trap, trap_cause}, 3'b101);
    chk("trap hold enables", enables(), 0);

    // Hung ALU hits the watchdog
    do_reset();
    enable = 1'b1;
    tv = '{3'd0, 5'd6, 32'h0, 1'b0, 32'h0,
           32'h0, 0, 1, 0, 32'h100, 11,
           0, 32'h0, 1, 2'd2, 0};
    run_vec(tv, "timeout");

    // Illegal class, reset returns PC to RESET_PC
    do_reset();
    enable = 1'b1;
    tv = '{3'd7, 5'd6, 32'h0, 1'b0, 32'h0,
           32'h0, 0, 0, 0, 32'h100, 2,
           0, 32'h0, 1, 2'd0, 0};
    run_vec(tv, "illegal");
    do_reset();
    chk("post pc", fetch_addr, 32'h100);
    chk("post state", {busy, trap}, 0);

    // ecall
    enable = 1'b1;
    tv = '{3'd5, 5'd6, 32'h0, 1'b0, 32'h0,
           32'h0, 0, 0, 0, 32'h100, 4,
           0, 32'h0, 1, 2'd3, 0};
    run_vec(tv, "ecall");
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench time limit");
  end

endmodule
